// File: rtl/lab3_dff_register_arbiter_if.sv
// lab3_dff_register_arbiter_if
// Bundles the two client request/data pairs with the grant/ack handshake and
// the shared register outputs. The arbiter takes the slave modport; the data
// sources (or a testbench) take the master modport.
interface lab3_dff_register_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             req0;
   logic [WIDTH-1:0] data0;
   logic             req1;
   logic [WIDTH-1:0] data1;
   logic             grant0;
   logic             grant1;
   logic             ack0;
   logic             ack1;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] NQ;
   logic             busy;
   logic             last_id;

   modport master (
      output req0, data0, req1, data1,
      input  grant0, grant1, ack0, ack1, Q, NQ, busy, last_id
   );

   modport slave (
      input  req0, data0, req1, data1,
      output grant0, grant1, ack0, ack1, Q, NQ, busy, last_id
   );
endinterface

// File: rtl/lab3_dff_register_arbiter.sv
// lab3_dff_register_arbiter
// Two-client arbiter in front of a shared WIDTH-bit D flip-flop register.
// One write is in flight at a time: IDLE picks a winner, GRANT lasts one
// cycle and loads the winner's data on its exit edge, ACK pulses the
// winner's acknowledge for one cycle, then the arbiter returns to IDLE.
// Ties go to the round-robin pointer, which flips to the other client after
// every write.
// Optional build macro: LAB3_ARB_FIXED_PRIORITY_EN -- when defined, the
// pointer is pinned at 0 so client 0 always wins ties (client 1 may starve).
module lab3_dff_register_arbiter #(
   parameter int WIDTH = 8
) (
   input logic                        clock,
   input logic                        reset_n,
   lab3_dff_register_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ACK   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             ptr_q, ptr_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             last_id_q, last_id_d;

   // Next-state logic: choose an owner in IDLE, commit the write on the GRANT exit edge
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      q_d       = q_q;
      last_id_d = last_id_q;
      case (state_q)
         IDLE: begin
            if (bus.req0 && bus.req1) begin
               owner_d = ptr_q;
               state_d = GRANT;
            end else if (bus.req0) begin
               owner_d = 1'b0;
               state_d = GRANT;
            end else if (bus.req1) begin
               owner_d = 1'b1;
               state_d = GRANT;
            end
         end
         GRANT: begin
            q_d       = owner_q ? bus.data1 : bus.data0;
            last_id_d = owner_q;
`ifdef LAB3_ARB_FIXED_PRIORITY_EN
            ptr_d     = 1'b0;
`else
            ptr_d     = ~owner_q;
`endif
            state_d   = ACK;
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, owner, pointer and the shared register itself; reset drops any pending write
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         ptr_q     <= 1'b0;
         q_q       <= '0;
         last_id_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         q_q       <= q_d;
         last_id_q <= last_id_d;
      end
   end

   // Handshake outputs decode straight from registered state, so reset clears them at once
   assign bus.grant0  = (state_q == GRANT) && !owner_q;
   assign bus.grant1  = (state_q == GRANT) &&  owner_q;
   assign bus.ack0    = (state_q == ACK)   && !owner_q;
   assign bus.ack1    = (state_q == ACK)   &&  owner_q;
   assign bus.busy    = (state_q == GRANT) || (state_q == ACK);
   assign bus.Q       = q_q;
   assign bus.NQ      = ~q_q;
   assign bus.last_id = last_id_q;

endmodule

// File: tb/tb_lab3_dff_register_arbiter.sv
// tb_lab3_dff_register_arbiter
// Drives the arbiter through directed scenarios and a randomized run. The
// reference model tracks whole write transactions by edge number: a write
// starting at edge t shows grant during t..t+1, commits data at t+1, shows
// ack during t+1..t+2, and the next request can only be taken at t+3.
module tb_lab3_dff_register_arbiter;
   localparam int WIDTH = 8;
`ifdef LAB3_ARB_FIXED_PRIORITY_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clock;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   lab3_dff_register_arbiter_if #(.WIDTH(WIDTH)) bus_if ();

   lab3_dff_register_arbiter #(.WIDTH(WIDTH)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Transaction-level reference model state
   int               e_cnt   = 0;
   int               t_start = 0;
   int               free_at = 0;
   bit               m_active;
   bit               m_owner;
   bit               m_ptr;
   bit               m_last;
   logic [WIDTH-1:0] m_q;

   task automatic model_reset();
      m_active = 1'b0;
      m_owner  = 1'b0;
      m_ptr    = 1'b0;
      m_last   = 1'b0;
      m_q      = '0;
      free_at  = 0;
   endtask

   task automatic model_edge();
      if (reset_n) begin
         e_cnt++;
         if (m_active && e_cnt == t_start + 1) begin
            m_q    = m_owner ? bus_if.data1 : bus_if.data0;
            m_last = m_owner;
            m_ptr  = FIXED ? 1'b0 : !m_owner;
         end
         if (m_active && e_cnt >= t_start + 2) m_active = 1'b0;
         if (!m_active && e_cnt >= free_at && (bus_if.req0 || bus_if.req1)) begin
            m_active = 1'b1;
            t_start  = e_cnt;
            free_at  = e_cnt + 3;
            m_owner  = (bus_if.req0 && bus_if.req1) ? m_ptr : bus_if.req1;
         end
      end
   endtask

   // Expected {grant0, grant1, ack0, ack1, busy, last_id} for the current cycle
   task automatic model_expect(output logic [5:0] ctl);
      bit g, a;
      g   = m_active && (e_cnt == t_start);
      a   = m_active && (e_cnt == t_start + 1);
      ctl = {g && !m_owner, g && m_owner, a && !m_owner, a && m_owner, g || a, m_last};
   endtask

   task automatic advance();
      @(posedge clock);
      model_edge();
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n       = 1'b0;
      bus_if.req0   = 1'b1;
      bus_if.data0  = 8'hA5;
      bus_if.req1   = 1'b0;
      bus_if.data1  = 8'h00;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         advance();
         checks++;
         if (bus_if.Q !== 8'h00 || bus_if.NQ !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL reset_q: Q=%h NQ=%h expected 00/ff", bus_if.Q, bus_if.NQ);
         end
         checks++;
         if ({bus_if.grant0, bus_if.grant1, bus_if.ack0, bus_if.ack1, bus_if.busy, bus_if.last_id} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctl: got %b expected 000000",
                     {bus_if.grant0, bus_if.grant1, bus_if.ack0, bus_if.ack1, bus_if.busy, bus_if.last_id});
         end
      end
      bus_if.req0 = 1'b0;
      reset_n     = 1'b1;
   endtask

   task automatic test_single_write();
      bus_if.data0 = 8'h3C;
      bus_if.req0  = 1'b1;
      advance();
      checks++;
      if ({bus_if.grant0, bus_if.grant1, bus_if.ack0, bus_if.ack1, bus_if.busy} !== 5'b10001) begin
         errors++;
         $display("[TB] FAIL single_grant: got %b expected 10001",
                  {bus_if.grant0, bus_if.grant1, bus_if.ack0, bus_if.ack1, bus_if.busy});
      end
      checks++;
      if (bus_if.Q !== 8'h00) begin
         errors++;
         $display("[TB] FAIL single_q_early: Q=%h expected 00", bus_if.Q);
      end
      advance();
      bus_if.req0 = 1'b0;
      checks++;
      if ({bus_if.grant0, bus_if.grant1, bus_if.ack0, bus_if.ack1, bus_if.busy} !== 5'b00101) begin
         errors++;
         $display("[TB] FAIL single_ack: got %b expected 00101",
                  {bus_if.grant0, bus_if.grant1, bus_if.ack0, bus_if.ack1, bus_if.busy});
      end
      checks++;
      if (bus_if.Q !== 8'h3C || bus_if.NQ !== 8'hC3 || bus_if.last_id !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_data: Q=%h NQ=%h last_id=%b expected 3c/c3/0",
                  bus_if.Q, bus_if.NQ, bus_if.last_id);
      end
      advance();
      checks++;
      if ({bus_if.grant0, bus_if.grant1, bus_if.ack0, bus_if.ack1, bus_if.busy} !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL single_idle: got %b expected 00000",
                  {bus_if.grant0, bus_if.grant1, bus_if.ack0, bus_if.ack1, bus_if.busy});
      end
      advance();
   endtask

   task automatic test_contention();
      int n;
      int last_k;
      bit exp_id;
      reset_n = 1'b0;
      model_reset();
      #1;
      reset_n = 1'b1;
      bus_if.data0 = 8'h11;
      bus_if.data1 = 8'h22;
      bus_if.req0  = 1'b1;
      bus_if.req1  = 1'b1;
      n      = 0;
      last_k = 0;
      for (int k = 1; k <= 12; k++) begin
         advance();
         checks++;
         if ((bus_if.grant0 && bus_if.grant1) || (bus_if.ack0 && bus_if.ack1)) begin
            errors++;
            $display("[TB] FAIL contention_excl: cycle %0d grants=%b%b acks=%b%b",
                     k, bus_if.grant0, bus_if.grant1, bus_if.ack0, bus_if.ack1);
         end
         if (bus_if.ack0 || bus_if.ack1) begin
            exp_id = FIXED ? 1'b0 : n[0];
            checks++;
            if (k != 2 + 3 * n) begin
               errors++;
               $display("[TB] FAIL contention_timing: ack %0d at cycle %0d expected cycle %0d (prev %0d)",
                        n, k, 2 + 3 * n, last_k);
            end
            checks++;
            if (bus_if.ack1 !== exp_id || bus_if.Q !== (exp_id ? 8'h22 : 8'h11)) begin
               errors++;
               $display("[TB] FAIL contention_order: ack %0d ack1=%b Q=%h expected ack1=%b Q=%h",
                        n, bus_if.ack1, bus_if.Q, exp_id, exp_id ? 8'h22 : 8'h11);
            end
            last_k = k;
            n++;
         end
      end
      checks++;
      if (n != 4) begin
         errors++;
         $display("[TB] FAIL contention_count: %0d acks expected 4", n);
      end
      bus_if.req0 = 1'b0;
      bus_if.req1 = 1'b0;
      advance();
      advance();
   endtask

   task automatic test_mid_reset();
      bus_if.data0 = 8'h3C;
      bus_if.req0  = 1'b1;
      advance();
      advance();
      bus_if.req0 = 1'b0;
      advance();
      checks++;
      if (bus_if.Q !== 8'h3C) begin
         errors++;
         $display("[TB] FAIL midrst_setup: Q=%h expected 3c", bus_if.Q);
      end
      bus_if.data1 = 8'h77;
      bus_if.req1  = 1'b1;
      advance();
      checks++;
      if (bus_if.grant1 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_grant1: grant1=%b expected 1", bus_if.grant1);
      end
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (bus_if.Q !== 8'h00 || bus_if.NQ !== 8'hFF || bus_if.grant1 !== 1'b0 || bus_if.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_async: Q=%h NQ=%h grant1=%b busy=%b expected 00/ff/0/0",
                  bus_if.Q, bus_if.NQ, bus_if.grant1, bus_if.busy);
      end
      for (int i = 0; i < 2; i++) begin
         advance();
         checks++;
         if (bus_if.ack1 !== 1'b0 || bus_if.Q !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midrst_noack: ack1=%b Q=%h expected 0/00", bus_if.ack1, bus_if.Q);
         end
      end
      reset_n      = 1'b1;
      bus_if.data0 = 8'hAA;
      bus_if.data1 = 8'hBB;
      bus_if.req0  = 1'b1;
      bus_if.req1  = 1'b1;
      advance();
      checks++;
      if (bus_if.grant0 !== 1'b1 || bus_if.grant1 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_ptr: grant0=%b grant1=%b expected 1/0", bus_if.grant0, bus_if.grant1);
      end
      advance();
      bus_if.req0 = 1'b0;
      bus_if.req1 = 1'b0;
      checks++;
      if (bus_if.ack0 !== 1'b1 || bus_if.Q !== 8'hAA) begin
         errors++;
         $display("[TB] FAIL midrst_write: ack0=%b Q=%h expected 1/aa", bus_if.ack0, bus_if.Q);
      end
      advance();
      advance();
   endtask

   task automatic test_late_drop();
      bus_if.req0  = 1'b0;
      bus_if.data1 = 8'h55;
      bus_if.req1  = 1'b1;
      advance();
      checks++;
      if (bus_if.grant1 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL late_grant1: grant1=%b expected 1", bus_if.grant1);
      end
      bus_if.req1  = 1'b0;
      bus_if.data1 = 8'h66;
      advance();
      checks++;
      if (bus_if.ack1 !== 1'b1 || bus_if.Q !== 8'h66 || bus_if.last_id !== 1'b1) begin
         errors++;
         $display("[TB] FAIL late_commit: ack1=%b Q=%h last_id=%b expected 1/66/1",
                  bus_if.ack1, bus_if.Q, bus_if.last_id);
      end
      advance();
      checks++;
      if (bus_if.ack1 !== 1'b0 || bus_if.grant1 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL late_single_ack: ack1=%b grant1=%b expected 0/0", bus_if.ack1, bus_if.grant1);
      end
      advance();
      bus_if.data1 = 8'h5A;
      bus_if.req1  = 1'b1;
      advance();
      advance();
      advance();
      checks++;
      if (bus_if.grant1 !== 1'b0 || bus_if.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL held_gap: grant1=%b busy=%b expected 0/0", bus_if.grant1, bus_if.busy);
      end
      advance();
      checks++;
      if (bus_if.grant1 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL held_regrant: grant1=%b expected 1", bus_if.grant1);
      end
      bus_if.req1 = 1'b0;
      advance();
      checks++;
      if (bus_if.ack1 !== 1'b1 || bus_if.Q !== 8'h5A) begin
         errors++;
         $display("[TB] FAIL held_commit: ack1=%b Q=%h expected 1/5a", bus_if.ack1, bus_if.Q);
      end
      advance();
   endtask

   task automatic test_random();
      logic [5:0] exp_ctl;
      logic [5:0] got_ctl;
      for (int i = 0; i < 400; i++) begin
         bus_if.req0  = ($urandom_range(0, 2) != 0);
         bus_if.req1  = ($urandom_range(0, 2) != 0);
         bus_if.data0 = WIDTH'($urandom);
         bus_if.data1 = WIDTH'($urandom);
         if ($urandom_range(0, 79) == 0) begin
            reset_n = 1'b0;
            model_reset();
         end else begin
            reset_n = 1'b1;
         end
         advance();
         model_expect(exp_ctl);
         got_ctl = {bus_if.grant0, bus_if.grant1, bus_if.ack0, bus_if.ack1, bus_if.busy, bus_if.last_id};
         checks++;
         if (got_ctl !== exp_ctl) begin
            errors++;
            $display("[TB] FAIL random_ctl: cycle %0d got %b expected %b", i, got_ctl, exp_ctl);
         end
         checks++;
         if (bus_if.Q !== m_q || bus_if.NQ !== ~m_q) begin
            errors++;
            $display("[TB] FAIL random_q: cycle %0d Q=%h NQ=%h expected %h/%h", i, bus_if.Q, bus_if.NQ, m_q, ~m_q);
         end
      end
      reset_n     = 1'b1;
      bus_if.req0 = 1'b0;
      bus_if.req1 = 1'b0;
      advance();
   endtask

   // Main sequence
   initial begin
      $display("[TB] starting, fixed priority build = %0d", FIXED);
      test_reset();
      test_single_write();
      test_contention();
      test_mid_reset();
      test_late_drop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Guard against a stuck simulation
   initial begin
      #200000;
      errors++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
